intc_apb_gen: RTL and testbench

- Parametrised APB interrupt controller: the next generation of the 8-source, byte-wide CONFREG interrupt logic.
- Collects NUM_INT asynchronous peripheral interrupt lines. Each line passes through a configurable synchroniser, then is qualified per channel (enable, level/edge, polarity, both-edge).
- Drives one aggregated int_o to the CPU, plus a fixed-priority vector (lowest index wins) readable over APB and presented on ports.
- Sits on the APB peripheral bus. psel is decoded upstream.

---
 rtl/intc_pkg.sv | 29 ++
 rtl/intc_apb_gen_if.sv | 32 +++
 rtl/intc_chan.sv | 58 +++++
 rtl/intc_apb_gen.sv | 175 +++++++++++++++++
 tb/tb_intc_apb_gen.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/intc_pkg.sv
// ============================================================================
//  Module      : intc_pkg
//  Description : Shared constants for the APB interrupt controller: register
//                byte offsets and the layout of the VEC register.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package intc_pkg;

    // Register byte offsets (only paddr[5:2] is decoded, so these are
    // compared against {paddr[5:2], 2'b00}).
    localparam logic [5:0] INTC_EN   = 6'h00;
    localparam logic [5:0] INTC_EDGE = 6'h04;
    localparam logic [5:0] INTC_POL  = 6'h08;
    localparam logic [5:0] INTC_BOTH = 6'h0C;
    localparam logic [5:0] INTC_CLR  = 6'h10;
    localparam logic [5:0] INTC_SET  = 6'h14;
    localparam logic [5:0] INTC_PEND = 6'h18;
    localparam logic [5:0] INTC_OUT  = 6'h1C;
    localparam logic [5:0] INTC_VEC  = 6'h20;

    // VEC register layout
    localparam int C_VEC_VALID_BIT = 31;
    localparam int C_ID_W          = 5;

endpackage : intc_pkg

`default_nettype wire

// File: rtl/intc_apb_gen_if.sv
// ============================================================================
//  Module      : intc_apb_gen_if
//  Description : APB peripheral bus bundle for the interrupt controller.
//                master : drives select/enable/write/address/write data
//                slave  : returns combinational read data and a fixed ack
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface intc_apb_gen_if #(
    parameter int ADDR_W = 20
);
    logic              apb_psel;
    logic              apb_penable;
    logic              apb_pwrite;
    logic [ADDR_W-1:0] apb_paddr;
    logic [31:0]       apb_pwdata;
    logic [31:0]       apb_prdata;
    logic              apb_ack;

    modport master (
        output apb_psel, apb_penable, apb_pwrite, apb_paddr, apb_pwdata,
        input  apb_prdata, apb_ack
    );

    modport slave (
        input  apb_psel, apb_penable, apb_pwrite, apb_paddr, apb_pwdata,
        output apb_prdata, apb_ack
    );
endinterface : intc_apb_gen_if

`default_nettype wire

// File: rtl/intc_chan.sv
// ============================================================================
//  Module      : intc_chan
//  Description : One interrupt channel: edge detection on the synchronised
//                input, the pending flop, and enable masking.
//  Ports       : clk/rst      - clock, async active-high reset
//                i_s / i_d    - synchronised input and its one-cycle delay
//                i_en/i_edge/i_pol/i_both - channel configuration bits
//                i_set/i_clr  - software set / clear of pending
//                o_pend       - pending flop
//                o_out        - masked channel output
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module intc_chan (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_s,
    input  wire logic i_d,
    input  wire logic i_en,
    input  wire logic i_edge,
    input  wire logic i_pol,
    input  wire logic i_both,
    input  wire logic i_set,
    input  wire logic i_clr,
    output logic      o_pend,
    output logic      o_out
);

    logic r_pend;
    logic w_level_act;
    logic w_det;

    assign w_level_act = (i_s == i_pol);

    // Detection runs whatever the mode or enable: PEND is observable and
    // only feeds OUT when the channel is in edge mode.
    assign w_det = (i_s != i_d) && (i_both || w_level_act);

    // An edge always wins, so a coincident software clear cannot lose it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend <= 1'b0;
        end else if (w_det) begin
            r_pend <= 1'b1;
        end else if (i_set) begin
            r_pend <= 1'b1;
        end else if (i_clr) begin
            r_pend <= 1'b0;
        end
    end

    assign o_pend = r_pend;
    assign o_out  = i_en && (i_edge ? r_pend : w_level_act);

endmodule : intc_chan

`default_nettype wire

// File: rtl/intc_apb_gen.sv
// ============================================================================
//  Module      : intc_apb_gen
//  Description : Parametrised APB interrupt controller. NUM_INT asynchronous
//                sources are synchronised, qualified per channel and combined
//                into one CPU interrupt plus a fixed-priority vector (lowest
//                index wins).
//  Ports       : apb_pclk/apb_rst - clock, async active-high reset
//                bus              - APB slave (zero wait states)
//                int_in           - raw asynchronous sources
//                int_o            - OR of all masked active channels
//                int_id/int_valid - highest-priority active channel
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module intc_apb_gen
    import intc_pkg::*;
#(
    parameter int          NUM_INT     = 16,
    parameter int          SYNC_STAGES = 2,
    parameter int          ADDR_W      = 20,
    parameter logic [31:0] EN_RST      = 32'h0000_0000,
    parameter logic [31:0] POL_RST     = 32'hFFFF_FFFF
) (
    input  wire logic               apb_pclk,
    input  wire logic               apb_rst,
    intc_apb_gen_if.slave           bus,
    input  wire logic [NUM_INT-1:0] int_in,
    output logic                    int_o,
    output logic [C_ID_W-1:0]       int_id,
    output logic                    int_valid
);

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic       w_wr;
    logic       w_rd;
    logic [5:0] w_off;
    logic       w_unused_bus;

    assign w_wr  = bus.apb_psel && bus.apb_penable &&  bus.apb_pwrite;
    assign w_rd  = bus.apb_psel && bus.apb_penable && !bus.apb_pwrite;
    assign w_off = {bus.apb_paddr[5:2], 2'b00};

    // Address bits outside [5:2] and write-data bits above NUM_INT are
    // intentionally ignored.
    assign w_unused_bus = ^{bus.apb_paddr[ADDR_W-1:0], bus.apb_pwdata};

    assign bus.apb_ack = 1'b1;

    // ------------------------------------------------------------------
    // Configuration registers
    // ------------------------------------------------------------------
    logic [NUM_INT-1:0] r_en;
    logic [NUM_INT-1:0] r_edge;
    logic [NUM_INT-1:0] r_pol;
    logic [NUM_INT-1:0] r_both;
    logic [NUM_INT-1:0] w_wdata;

    assign w_wdata = bus.apb_pwdata[NUM_INT-1:0];

    always_ff @(posedge apb_pclk or posedge apb_rst) begin
        if (apb_rst) begin
            r_en   <= EN_RST[NUM_INT-1:0];
            r_edge <= '0;
            r_pol  <= POL_RST[NUM_INT-1:0];
            r_both <= '0;
        end else if (w_wr) begin
            if (w_off == INTC_EN)   r_en   <= w_wdata;
            if (w_off == INTC_EDGE) r_edge <= w_wdata;
            if (w_off == INTC_POL)  r_pol  <= w_wdata;
            if (w_off == INTC_BOTH) r_both <= w_wdata;
        end
    end

    // SET/CLR are write-only strobes applied for the single write cycle.
    logic [NUM_INT-1:0] w_set;
    logic [NUM_INT-1:0] w_clr;

    assign w_set = (w_wr && (w_off == INTC_SET)) ? w_wdata : '0;
    assign w_clr = (w_wr && (w_off == INTC_CLR)) ? w_wdata : '0;

    // ------------------------------------------------------------------
    // Synchroniser: SYNC_STAGES-deep shift register, then one delay flop
    // used for edge detection.
    // ------------------------------------------------------------------
    logic [NUM_INT-1:0] r_sync [SYNC_STAGES];
    logic [NUM_INT-1:0] r_dly;
    logic [NUM_INT-1:0] w_s;

    always_ff @(posedge apb_pclk or posedge apb_rst) begin
        if (apb_rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                r_sync[k] <= '0;
            end
            r_dly <= '0;
        end else begin
            r_sync[0] <= int_in;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                r_sync[k] <= r_sync[k-1];
            end
            r_dly <= r_sync[SYNC_STAGES-1];
        end
    end

    assign w_s = r_sync[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Channels
    // ------------------------------------------------------------------
    logic [NUM_INT-1:0] w_pend;
    logic [NUM_INT-1:0] w_out;

    for (genvar i = 0; i < NUM_INT; i++) begin : g_chan
        intc_chan u_chan (
            .clk    (apb_pclk),
            .rst    (apb_rst),
            .i_s    (w_s[i]),
            .i_d    (r_dly[i]),
            .i_en   (r_en[i]),
            .i_edge (r_edge[i]),
            .i_pol  (r_pol[i]),
            .i_both (r_both[i]),
            .i_set  (w_set[i]),
            .i_clr  (w_clr[i]),
            .o_pend (w_pend[i]),
            .o_out  (w_out[i])
        );
    end

    // ------------------------------------------------------------------
    // Aggregation and fixed-priority vector (lowest index wins: scan from
    // the top so the last hit is the lowest index).
    // ------------------------------------------------------------------
    logic [C_ID_W-1:0] w_id;

    always_comb begin
        w_id = '0;
        for (int i = NUM_INT - 1; i >= 0; i--) begin
            if (w_out[i]) begin
                w_id = C_ID_W'(i);
            end
        end
    end

    assign int_o     = |w_out;
    assign int_valid = |w_out;
    assign int_id    = w_id;

    // ------------------------------------------------------------------
    // Read mux (combinational, zero when not reading)
    // ------------------------------------------------------------------
    always_comb begin
        bus.apb_prdata = '0;
        if (w_rd) begin
            case (w_off)
                INTC_EN:   bus.apb_prdata[NUM_INT-1:0] = r_en;
                INTC_EDGE: bus.apb_prdata[NUM_INT-1:0] = r_edge;
                INTC_POL:  bus.apb_prdata[NUM_INT-1:0] = r_pol;
                INTC_BOTH: bus.apb_prdata[NUM_INT-1:0] = r_both;
                INTC_PEND: bus.apb_prdata[NUM_INT-1:0] = w_pend;
                INTC_OUT:  bus.apb_prdata[NUM_INT-1:0] = w_out;
                INTC_VEC: begin
                    bus.apb_prdata[C_VEC_VALID_BIT] = int_valid;
                    bus.apb_prdata[C_ID_W-1:0]      = int_id;
                end
                default:   bus.apb_prdata = '0;
            endcase
        end
    end

endmodule : intc_apb_gen

`default_nettype wire

// File: tb/tb_intc_apb_gen.sv
// ============================================================================
//  Module      : tb_intc_apb_gen
//  Description : Self-checking bench for intc_apb_gen (NUM_INT=16,
//                SYNC_STAGES=2). Expected values are queued when stimulus is
//                issued and popped when the DUT output is sampled.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_intc_apb_gen;

    localparam int ADDR_W = 20;

    logic        clk;
    logic        rst;
    logic [15:0] int_in;
    logic        int_o;
    logic [4:0]  int_id;
    logic        int_valid;

    int n_checks = 0;
    int n_fail   = 0;

    intc_apb_gen_if #(.ADDR_W(ADDR_W)) bus ();

    intc_apb_gen #(
        .NUM_INT     (16),
        .SYNC_STAGES (2),
        .ADDR_W      (ADDR_W),
        .EN_RST      (32'h0),
        .POL_RST     (32'hFFFF_FFFF)
    ) u_dut (
        .apb_pclk  (clk),
        .apb_rst   (rst),
        .bus       (bus),
        .int_in    (int_in),
        .int_o     (int_o),
        .int_id    (int_id),
        .int_valid (int_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    string       tag_q [$];
    logic [31:0] exp_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] exp);
        tag_q.push_back(tag);
        exp_q.push_back(exp);
    endtask

    task automatic sb_pop(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", obs, 32'hDEAD_BEEF);
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            chk(t, obs, e);
        end
    endtask

    // ------------------------------------------------------------------
    // Stimulus helpers (all drive #1 after a rising edge)
    // ------------------------------------------------------------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apb_write(input logic [7:0] addr, input logic [31:0] data);
        @(posedge clk); #1;
        bus.apb_psel    = 1'b1;
        bus.apb_pwrite  = 1'b1;
        bus.apb_paddr   = ADDR_W'(addr);
        bus.apb_pwdata  = data;
        bus.apb_penable = 1'b0;
        @(posedge clk); #1;
        bus.apb_penable = 1'b1;
        @(posedge clk); #1;
        bus.apb_psel    = 1'b0;
        bus.apb_penable = 1'b0;
        bus.apb_pwrite  = 1'b0;
    endtask

    task automatic apb_read(input string tag, input logic [7:0] addr, input logic [31:0] exp);
        sb_push(tag, exp);
        @(posedge clk); #1;
        bus.apb_psel    = 1'b1;
        bus.apb_pwrite  = 1'b0;
        bus.apb_paddr   = ADDR_W'(addr);
        bus.apb_penable = 1'b0;
        @(posedge clk); #1;
        bus.apb_penable = 1'b1;
        #1;
        sb_pop(bus.apb_prdata);
        bus.apb_psel    = 1'b0;
        bus.apb_penable = 1'b0;
    endtask

    task automatic chk_int(input string tag, input logic exp);
        sb_push(tag, {31'b0, exp});
        sb_pop({31'b0, int_o});
    endtask

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin
        rst             = 1'b1;
        int_in          = '0;
        bus.apb_psel    = 1'b0;
        bus.apb_penable = 1'b0;
        bus.apb_pwrite  = 1'b0;
        bus.apb_paddr   = '0;
        bus.apb_pwdata  = '0;
        tick(3);
        rst = 1'b0;
        tick(1);

        // Reset state
        apb_read("rst_en",   8'h00, 32'h0000_0000);
        apb_read("rst_edge", 8'h04, 32'h0000_0000);
        apb_read("rst_pol",  8'h08, 32'h0000_FFFF);
        apb_read("rst_pend", 8'h18, 32'h0000_0000);
        apb_read("rst_vec",  8'h20, 32'h0000_0000);
        chk_int("rst_int_o", 1'b0);
        sb_push("idle_prdata", 32'h0);
        sb_pop(bus.apb_prdata);
        sb_push("ack", 32'h1);
        sb_pop({31'b0, bus.apb_ack});

        // Level mode on channel 3: exactly two edges of latency
        apb_write(8'h00, 32'h0000_0008);
        int_in[3] = 1'b1;
        tick(1); chk_int("lvl_rise_1clk", 1'b0);
        tick(1); chk_int("lvl_rise_2clk", 1'b1);
        apb_read("lvl_vec", 8'h20, 32'h8000_0003);
        sb_push("lvl_id_port", 32'd3);
        sb_pop({27'b0, int_id});
        int_in[3] = 1'b0;
        tick(1); chk_int("lvl_fall_1clk", 1'b1);
        tick(1); chk_int("lvl_fall_2clk", 1'b0);

        // Edge mode, active-low on channel 5: three edges of latency
        apb_write(8'h08, 32'h0000_FFDF);
        apb_write(8'h04, 32'h0000_0020);
        apb_write(8'h00, 32'h0000_0020);
        apb_write(8'h10, 32'h0000_FFFF);
        int_in[5] = 1'b1;
        tick(4); chk_int("edge_inactive_rise", 1'b0);
        int_in[5] = 1'b0;
        tick(2); chk_int("edge_fall_2clk", 1'b0);
        tick(1); chk_int("edge_fall_3clk", 1'b1);
        apb_read("edge_pend", 8'h18, 32'h0000_0020);
        apb_write(8'h10, 32'h0000_0020);
        chk_int("edge_after_clr", 1'b0);

        // Both-edge mode on channel 0
        apb_write(8'h00, 32'h0000_0001);
        apb_write(8'h04, 32'h0000_0001);
        apb_write(8'h0C, 32'h0000_0001);
        apb_write(8'h10, 32'h0000_FFFF);
        int_in[0] = 1'b1;
        tick(4);
        apb_read("both_rise_pend", 8'h18, 32'h0000_0001);
        apb_write(8'h10, 32'h0000_0001);
        apb_read("both_cleared", 8'h18, 32'h0000_0000);
        int_in[0] = 1'b0;
        tick(4);
        apb_read("both_fall_pend", 8'h18, 32'h0000_0001);

        // Priority: level channels 2 and 7
        apb_write(8'h04, 32'h0);
        apb_write(8'h0C, 32'h0);
        apb_write(8'h08, 32'h0000_FFFF);
        apb_write(8'h00, 32'h0000_0084);
        int_in[2] = 1'b1;
        int_in[7] = 1'b1;
        tick(3);
        apb_read("prio_vec", 8'h20, 32'h8000_0002);
        apb_read("prio_out", 8'h1C, 32'h0000_0084);

        // Collision: edge on ch2 lands on the same edge as a CLR write
        apb_write(8'h04, 32'h0000_0004);
        apb_write(8'h00, 32'h0000_0004);
        int_in[2] = 1'b0;
        tick(4);
        apb_write(8'h10, 32'h0000_FFFF);
        apb_read("coll_pre", 8'h18, 32'h0000_0000);
        int_in[2] = 1'b1;
        apb_write(8'h10, 32'h0000_0004);
        apb_read("coll_pend", 8'h18, 32'h0000_0004);

        // Software SET on channel 15; upper bits ignored
        apb_write(8'h10, 32'h0000_FFFF);
        apb_write(8'h00, 32'h0000_8000);
        apb_write(8'h04, 32'h0000_8000);
        chk_int("set_before", 1'b0);
        apb_write(8'h14, 32'h0000_8000);
        chk_int("set_int_o", 1'b1);
        apb_read("set_vec", 8'h20, 32'h8000_000F);
        apb_write(8'h00, 32'h0010_8000);
        apb_read("en_upper_bits", 8'h00, 32'h0000_8000);
        apb_read("clr_reads_0", 8'h10, 32'h0000_0000);
        apb_read("unmapped", 8'h24, 32'h0000_0000);

        if (exp_q.size() != 0) begin
            chk("scoreboard_leftover", 32'(exp_q.size()), 32'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule : tb_intc_apb_gen

`default_nettype wire
